axi_lite_ram_slave: RTL and testbench
=====================================

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 SHALL have parameter DEPTH, default 4096, RAM depth in words; must be a power of two.
REQ-004 SHALL have parameter BASE, default 0, byte base address, aligned to the RAM size.
REQ-005 clock  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 io_awvalid / io_awready  in / out  1  write-address handshake.
REQ-008 io_awaddr  in  ADDR_W  write byte address.
REQ-009 io_wvalid / io_wready  in / out  1  write-data handshake.
REQ-010 io_wdata  in  DATA_W  write data.
REQ-011 io_wstrb  in  DATA_W/8  byte-lane enables.
REQ-012 io_bvalid / io_bready  out / in  1  write-response handshake.
REQ-013 io_bresp  out  2  OKAY=00, DECERR=11.
REQ-014 io_arvalid / io_arready  in / out  1  read-address handshake.
REQ-015 io_araddr  in  ADDR_W  read byte address.
REQ-016 io_rvalid / io_rready  out / in  1  read-response handshake.
REQ-017 io_rdata  out  DATA_W  read data.
REQ-018 io_rresp  out  2  OKAY=00, DECERR=11.

Function
REQ-019 Read and write channels SHALL be independent FSMs that operate concurrently.
REQ-020 Word index SHALL be (addr - BASE) >> log2(DATA_W/8); low byte-offset bits are ignored (no alignment error).
REQ-021 An address SHALL be in range iff BASE <= addr < BASE + DEPTH*DATA_W/8; otherwise DECERR, with no RAM access.
REQ-022 Read FSM SHALL have states R_IDLE -> R_READ -> R_RESP -> R_IDLE; io_arready = (R_IDLE).
REQ-023 R_IDLE SHALL go to R_READ on arvalid; R_READ SHALL issue the RAM read (if in range); R_RESP SHALL hold rvalid until rready.
REQ-024 Read latency SHALL be: rvalid asserted exactly 2 cycles after the AR handshake; rdata and rresp stable while rvalid && !rready.
REQ-025 A DECERR read SHALL return rdata = 0.
REQ-026 Write FSM SHALL have states W_COLLECT -> W_WRITE -> W_RESP -> W_COLLECT.
REQ-027 In W_COLLECT, awready = !aw_held and wready = !w_held; AW and W SHALL be accepted in either order or in the same cycle.
REQ-028 W_COLLECT SHALL go to W_WRITE in the cycle after both AW and W are held.
REQ-029 W_WRITE SHALL write the lanes selected by wstrb (if in range) in one cycle; W_RESP SHALL hold bvalid until bready.
REQ-030 wstrb = 0 SHALL give bresp OKAY with the RAM unchanged.
REQ-031 If W_WRITE and R_READ hit the same word in the same cycle, the read SHALL return the pre-write data (read-first).
REQ-032 Throughput SHALL be one read per 3 cycles and one write per 3 cycles when rready/bready are held high.

Reset
REQ-033 Reset SHALL force R_IDLE and W_COLLECT, clear the held flags, and drive rvalid = bvalid = 0 and rdata, rresp, bresp = 0; RAM contents are not reset and are undefined after reset.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction without a response; a write SHALL NOT commit unless it was already in W_WRITE before the reset edge.

Structure
REQ-035 AXI response codes (OKAY, SLVERR, DECERR) and FSM state encodings SHALL live in shared package axi_pkg.
REQ-036 Storage SHALL be sub-module axi_ram_core: parametrised 1R1W synchronous RAM with per-byte write mask and read-first semantics.

Verification
REQ-037 DATA_W=32, BASE=0x8000_0000: write 0x8000_0010 with 0xDEADBEEF and strobe F, then read it -> bresp 00; rdata 0xDEADBEEF 2 cycles after AR.
REQ-038 Present W 3 cycles before AW (strobe 0x3, data 0x0000_1234 over 0xFFFFFFFF) -> wready low after the W handshake; read-back 0xFFFF_1234.
REQ-039 Write 0x8000_4000 (first address past the end), then read 0x7FFF_FFFC -> bresp 11 and no RAM change; rresp 11 with rdata 0.
REQ-040 Hold rready low for 5 cycles -> rvalid and rdata stable; arready stays low until rready rises.
REQ-041 Same-cycle W_WRITE/R_READ to word 4 (old 0x1, new 0x2) -> rdata 0x1; a following read returns 0x2.
REQ-042 Assert reset during R_RESP and during W_COLLECT with AW held -> outputs return to reset values; the next write completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI-Lite definitions: response codes and the channel FSM encodings
// used by the RAM slave.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_READ = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    typedef enum logic [1:0] {
        W_COLLECT = 2'b00,
        W_WRITE   = 2'b01,
        W_RESP    = 2'b10
    } wr_state_e;

endpackage

// File: rtl/axi_ram_core.sv
// 1R1W synchronous RAM with per-byte write mask; a read in the same cycle as a
// write to the same word returns the old contents.
module axi_ram_core #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en_i,
    input  logic                  rd_zero_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [DATA_W-1:0]     rd_data_o,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [DATA_W/8-1:0]   wr_strb_i
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Byte-masked write port; the array itself is never reset.
    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_strb_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    // Read data register: holds between reads, can be forced to zero for decode errors.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end else if (rd_zero_i) begin
            rd_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI-Lite slave fronting a word RAM; read and write channels run as
// independent FSMs, out-of-window addresses answer DECERR without touching RAM.
module axi_lite_ram_slave
    import axi_pkg::*;
#(
    parameter int unsigned       DATA_W = 32,
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = {ADDR_W{1'b0}}
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_awvalid,
    output logic                  io_awready,
    input  logic [ADDR_W-1:0]     io_awaddr,
    input  logic                  io_wvalid,
    output logic                  io_wready,
    input  logic [DATA_W-1:0]     io_wdata,
    input  logic [DATA_W/8-1:0]   io_wstrb,
    output logic                  io_bvalid,
    input  logic                  io_bready,
    output logic [1:0]            io_bresp,
    input  logic                  io_arvalid,
    output logic                  io_arready,
    input  logic [ADDR_W-1:0]     io_araddr,
    output logic                  io_rvalid,
    input  logic                  io_rready,
    output logic [DATA_W-1:0]     io_rdata,
    output logic [1:0]            io_rresp
);

    localparam int unsigned      NB        = DATA_W / 8;
    localparam int unsigned      BYTE_LSB  = $clog2(NB);
    localparam int unsigned      IDX_W     = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  RAM_BYTES = (ADDR_W+1)'(DEPTH * NB);

    // One extra bit so addresses below BASE show up as a borrow.
    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return (off[ADDR_W] == 1'b0) && (off < RAM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = (a - BASE) >> BYTE_LSB;
        return IDX_W'(off);
    endfunction

    rd_state_e           r_state_q, r_state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rd_hit_s, rd_en_s, rd_zero_s;

    wr_state_e           w_state_q, w_state_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]       wstrb_q, wstrb_d;
    logic                aw_held_q, aw_held_d;
    logic                w_held_q, w_held_d;
    logic                awready_q, awready_d;
    logic                wready_q, wready_d;
    logic                bvalid_q, bvalid_d;
    logic [1:0]          bresp_q, bresp_d;
    logic                wr_hit_s, wr_en_s, aw_hs_s, w_hs_s;

    assign rd_hit_s = addr_hit(araddr_q);
    assign wr_hit_s = addr_hit(awaddr_q);
    assign aw_hs_s  = io_awvalid && awready_q;
    assign w_hs_s   = io_wvalid && wready_q;

    // Read channel next state: address capture, RAM read, response hold.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rd_en_s   = 1'b0;
        rd_zero_s = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (io_arvalid) begin
                    araddr_d  = io_araddr;
                    r_state_d = R_READ;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_READ: begin
                rd_en_s   = rd_hit_s;
                rd_zero_s = !rd_hit_s;
                rresp_d   = rd_hit_s ? RESP_OKAY : RESP_DECERR;
                rvalid_d  = 1'b1;
                r_state_d = R_RESP;
            end
            R_RESP: begin
                if (io_rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end else begin
                    r_state_d = R_RESP;
                end
            end
            default: begin
                rvalid_d  = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // Read channel registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            araddr_q  <= {ADDR_W{1'b0}};
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    // Write channel next state: AW/W gathered in any order, then one write cycle.
    always_comb begin
        w_state_d = w_state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_en_s   = 1'b0;
        case (w_state_q)
            W_COLLECT: begin
                if (aw_hs_s) begin
                    awaddr_d  = io_awaddr;
                    aw_held_d = 1'b1;
                end else begin
                    aw_held_d = aw_held_q;
                end
                if (w_hs_s) begin
                    wdata_d  = io_wdata;
                    wstrb_d  = io_wstrb;
                    w_held_d = 1'b1;
                end else begin
                    w_held_d = w_held_q;
                end
                if (aw_held_d && w_held_d) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_WRITE;
                end else begin
                    w_state_d = W_COLLECT;
                end
            end
            W_WRITE: begin
                wr_en_s   = wr_hit_s && (wstrb_q != {NB{1'b0}});
                bresp_d   = wr_hit_s ? RESP_OKAY : RESP_DECERR;
                bvalid_d  = 1'b1;
                w_state_d = W_RESP;
            end
            W_RESP: begin
                if (io_bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_COLLECT;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                aw_held_d = 1'b0;
                w_held_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_COLLECT;
            end
        endcase
        awready_d = (w_state_d == W_COLLECT) && !aw_held_d;
        wready_d  = (w_state_d == W_COLLECT) && !w_held_d;
    end

    // Write channel registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_state_q <= W_COLLECT;
            awaddr_q  <= {ADDR_W{1'b0}};
            wdata_q   <= {DATA_W{1'b0}};
            wstrb_q   <= {NB{1'b0}};
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            w_state_q <= w_state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    axi_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .rd_en_i   (rd_en_s),
        .rd_zero_i (rd_zero_s),
        .rd_idx_i  (word_idx(araddr_q)),
        .rd_data_o (io_rdata),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (word_idx(awaddr_q)),
        .wr_data_i (wdata_q),
        .wr_strb_i (wstrb_q)
    );

    assign io_arready = arready_q;
    assign io_rvalid  = rvalid_q;
    assign io_rresp   = rresp_q;
    assign io_awready = awready_q;
    assign io_wready  = wready_q;
    assign io_bvalid  = bvalid_q;
    assign io_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed bench for axi_lite_ram_slave (32-bit data, window at 0x8000_0000).
module tb_axi_lite_ram_slave;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_awvalid = 1'b0;
    logic        io_awready;
    logic [31:0] io_awaddr = 32'h0;
    logic        io_wvalid = 1'b0;
    logic        io_wready;
    logic [31:0] io_wdata = 32'h0;
    logic [3:0]  io_wstrb = 4'h0;
    logic        io_bvalid;
    logic        io_bready = 1'b1;
    logic [1:0]  io_bresp;
    logic        io_arvalid = 1'b0;
    logic        io_arready;
    logic [31:0] io_araddr = 32'h0;
    logic        io_rvalid;
    logic        io_rready = 1'b1;
    logic [31:0] io_rdata;
    logic [1:0]  io_rresp;

    int total = 0;
    int bad   = 0;

    axi_lite_ram_slave #(
        .DATA_W (32),
        .ADDR_W (32),
        .DEPTH  (4096),
        .BASE   (32'h8000_0000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_awvalid (io_awvalid),
        .io_awready (io_awready),
        .io_awaddr  (io_awaddr),
        .io_wvalid  (io_wvalid),
        .io_wready  (io_wready),
        .io_wdata   (io_wdata),
        .io_wstrb   (io_wstrb),
        .io_bvalid  (io_bvalid),
        .io_bready  (io_bready),
        .io_bresp   (io_bresp),
        .io_arvalid (io_arvalid),
        .io_arready (io_arready),
        .io_araddr  (io_araddr),
        .io_rvalid  (io_rvalid),
        .io_rready  (io_rready),
        .io_rdata   (io_rdata),
        .io_rresp   (io_rresp)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // w_lead: cycles W is presented before AW (0 = same cycle).
    task automatic wr_chk(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, input logic [1:0] exp_resp);
        int   cyc;
        bit   aw_done, w_done, aw_hs, w_hs;
        logic [1:0] resp;
        io_bready  = 1'b1;
        io_awaddr  = a;
        io_wdata   = d;
        io_wstrb   = s;
        io_wvalid  = 1'b1;
        io_awvalid = (w_lead == 0);
        aw_done = 1'b0;
        w_done  = 1'b0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_hs = io_awvalid && io_awready;
            w_hs  = io_wvalid && io_wready;
            tick();
            cyc++;
            if (aw_hs) begin io_awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin io_wvalid  = 1'b0; w_done  = 1'b1; end
            if (w_done && !aw_done) chk({tag, "_wready_low"}, {63'd0, io_wready}, 64'd0);
            if (cyc == w_lead && !aw_done) io_awvalid = 1'b1;
        end
        io_awvalid = 1'b0;
        io_wvalid  = 1'b0;
        cyc = 0;
        while (!io_bvalid && cyc < 10) begin tick(); cyc++; end
        resp = io_bvalid ? io_bresp : 2'bxx;
        chk({tag, "_bresp"}, {62'd0, resp}, {62'd0, exp_resp});
        tick();
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n, lat;
        io_rready  = 1'b1;
        io_araddr  = a;
        io_arvalid = 1'b1;
        n = 0;
        while (!io_arready && n < 10) begin tick(); n++; end
        tick();
        io_arvalid = 1'b0;
        lat = 1;
        while (!io_rvalid && lat < 10) begin tick(); lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'd2);
        chk({tag, "_rdata"}, {32'd0, io_rvalid ? io_rdata : 32'hxxxx_xxxx}, {32'd0, exp_data});
        chk({tag, "_rresp"}, {62'd0, io_rresp}, {62'd0, exp_resp});
        tick();
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_arready", {63'd0, io_arready}, 64'd1);
        chk("rst_awready", {63'd0, io_awready}, 64'd1);
        chk("rst_wready",  {63'd0, io_wready},  64'd1);
        chk("rst_rvalid",  {63'd0, io_rvalid},  64'd0);
        chk("rst_bvalid",  {63'd0, io_bvalid},  64'd0);
        chk("rst_rdata",   {32'd0, io_rdata},   64'd0);
        chk("rst_resp",    {60'd0, io_rresp, io_bresp}, 64'd0);
        reset = 1'b0;
        tick();

        // Basic write/read and the top word of the window
        wr_chk("basic_wr", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2'b00);
        rd_chk("basic_rd", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);
        wr_chk("top_wr", 32'h8000_3FFC, 32'h1357_9BDF, 4'hF, 0, 2'b00);
        rd_chk("top_rd", 32'h8000_3FFE, 32'h1357_9BDF, 2'b00);

        // W before AW with partial strobe, then an all-zero strobe
        wr_chk("fill_wr", 32'h8000_0030, 32'hFFFF_FFFF, 4'hF, 0, 2'b00);
        wr_chk("wfirst_wr", 32'h8000_0030, 32'h0000_1234, 4'h3, 3, 2'b00);
        rd_chk("wfirst_rd", 32'h8000_0030, 32'hFFFF_1234, 2'b00);
        wr_chk("strb0_wr", 32'h8000_0030, 32'hAAAA_AAAA, 4'h0, 0, 2'b00);
        rd_chk("strb0_rd", 32'h8000_0030, 32'hFFFF_1234, 2'b00);

        // Write and read of word 4 in the same cycle: read sees old data
        wr_chk("w4_init", 32'h8000_0010, 32'h0000_0001, 4'hF, 0, 2'b00);
        io_awaddr = 32'h8000_0010; io_wdata = 32'h0000_0002; io_wstrb = 4'hF;
        io_araddr = 32'h8000_0010;
        io_awvalid = 1'b1; io_wvalid = 1'b1; io_arvalid = 1'b1;
        tick();
        io_awvalid = 1'b0; io_wvalid = 1'b0; io_arvalid = 1'b0;
        tick();
        chk("rf_rvalid", {63'd0, io_rvalid}, 64'd1);
        chk("rf_bvalid", {63'd0, io_bvalid}, 64'd1);
        chk("rf_rdata",  {32'd0, io_rdata},  64'd1);
        tick();
        rd_chk("rf_after", 32'h8000_0010, 32'h0000_0002, 2'b00);

        // Out-of-window accesses
        wr_chk("w0_init",  32'h8000_0000, 32'hA5A5_A5A5, 4'hF, 0, 2'b00);
        wr_chk("w24_init", 32'h8000_0024, 32'h1111_1111, 4'hF, 0, 2'b00);
        wr_chk("oob_wr", 32'h8000_4000, 32'hBAD0_BAD0, 4'hF, 0, 2'b11);
        rd_chk("oob_rd", 32'h7FFF_FFFC, 32'h0000_0000, 2'b11);
        rd_chk("oob_nochg", 32'h8000_0000, 32'hA5A5_A5A5, 2'b00);

        // Read response stalled by rready low
        io_rready  = 1'b0;
        io_araddr  = 32'h8000_0030;
        io_arvalid = 1'b1;
        tick();
        io_arvalid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_rvalid",  {63'd0, io_rvalid},  64'd1);
            chk("stall_rdata",   {32'd0, io_rdata},   64'h0000_0000_FFFF_1234);
            chk("stall_arready", {63'd0, io_arready}, 64'd0);
            tick();
        end
        io_rready = 1'b1;
        tick();
        chk("stall_done_rvalid",  {63'd0, io_rvalid},  64'd0);
        chk("stall_done_arready", {63'd0, io_arready}, 64'd1);

        // Reset while a read response is pending
        io_rready  = 1'b0;
        io_araddr  = 32'h8000_0030;
        io_arvalid = 1'b1;
        tick();
        io_arvalid = 1'b0;
        tick();
        chk("rrst_pre_rvalid", {63'd0, io_rvalid}, 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("rrst_rvalid",  {63'd0, io_rvalid},  64'd0);
        chk("rrst_rdata",   {32'd0, io_rdata},   64'd0);
        chk("rrst_arready", {63'd0, io_arready}, 64'd1);
        #1 reset = 1'b0;
        io_rready = 1'b1;
        tick();

        // Reset in W_COLLECT with only AW held
        io_awaddr  = 32'h8000_0024;
        io_awvalid = 1'b1;
        tick();
        io_awvalid = 1'b0;
        chk("wrst_pre_awready", {63'd0, io_awready}, 64'd0);
        chk("wrst_pre_wready",  {63'd0, io_wready},  64'd1);
        #1 reset = 1'b1;
        #1;
        chk("wrst_awready", {63'd0, io_awready}, 64'd1);
        chk("wrst_bvalid",  {63'd0, io_bvalid},  64'd0);
        chk("wrst_bresp",   {62'd0, io_bresp},   64'd0);
        #1 reset = 1'b0;
        tick();
        wr_chk("post_rst_wr", 32'h8000_0020, 32'hCAFE_F00D, 4'hF, 0, 2'b00);
        rd_chk("post_rst_rd", 32'h8000_0020, 32'hCAFE_F00D, 2'b00);
        rd_chk("aborted_addr", 32'h8000_0024, 32'h1111_1111, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
